// File: rtl/intr_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : intr_request_ctrl
//  Description : Edge-captured pending sources, priority request to the CPU,
//                and an in-service stack that tracks interrupt nesting.
//  Revision    : 1.0 - initial release
// ============================================================================
module intr_request_ctrl #(
    parameter int NUM_SRC = 3,
    parameter int NO_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               int_en,
    input  logic               intr_ack,
    input  logic [NO_W-1:0]    clrNo,
    output logic               IntrRequest,
    output logic [NO_W-1:0]    ReqNo,
    output logic [NO_W-1:0]    IntNo,
    output logic [NUM_SRC-1:0] pending,
    output logic [NO_W-1:0]    depth,
    output logic               clr_err
);

    localparam int         c_STACK_N = 2**NO_W;
    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_REQ     = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_stateNext;
    logic [NUM_SRC-1:0] r_irqD;
    logic [NUM_SRC-1:0] r_pending;
    logic [NO_W-1:0]    r_stack [c_STACK_N];
    logic [NO_W-1:0]    r_depth;
    logic [NO_W-1:0]    r_intNo;
    logic               r_intrRequest;
    logic [NO_W-1:0]    r_reqNo;
    logic               r_clrErr;

    logic [NUM_SRC-1:0] w_edges;
    logic [NUM_SRC-1:0] w_ackMask;
    logic [NO_W-1:0]    w_best;
    logic               w_popOk;
    logic               w_clrBad;
    logic [NO_W-1:0]    w_depthPop;
    logic [NO_W-1:0]    w_topPop;
    logic               w_push;
    logic               w_reqNext;
    logic [NO_W-1:0]    w_reqNoNext;

    assign w_edges = irq_in & ~r_irqD;

    // Highest-numbered pending source wins.
    always_comb begin
        w_best = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_pending[i]) begin
                w_best = NO_W'(i + 1);
            end
        end
    end

    // Clear is resolved before any push in the same cycle.
    assign w_popOk    = (clrNo != '0) && (clrNo == r_intNo);
    assign w_clrBad   = (clrNo != '0) && !w_popOk;
    assign w_depthPop = r_depth - NO_W'(w_popOk);
    assign w_topPop   = (w_depthPop == '0) ? '0 : r_stack[w_depthPop - NO_W'(1)];

    always_comb begin
        w_stateNext = r_state;
        w_reqNext   = r_intrRequest;
        w_reqNoNext = r_reqNo;
        w_push      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (int_en && (w_best > r_intNo)) begin
                    w_stateNext = c_REQ;
                    w_reqNext   = 1'b1;
                    w_reqNoNext = w_best;
                end
            end
            c_REQ: begin
                if (intr_ack) begin
                    w_push      = 1'b1;
                    w_stateNext = c_IDLE;
                    w_reqNext   = 1'b0;
                    w_reqNoNext = '0;
                end else if (!int_en) begin
                    w_stateNext = c_IDLE;
                    w_reqNext   = 1'b0;
                    w_reqNoNext = '0;
                end
            end
            default: begin
                w_stateNext = c_IDLE;
                w_reqNext   = 1'b0;
                w_reqNoNext = '0;
            end
        endcase
    end

    always_comb begin
        w_ackMask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push && (r_reqNo == NO_W'(i + 1))) begin
                w_ackMask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_intrRequest <= 1'b0;
            r_reqNo       <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_intrRequest <= w_reqNext;
            r_reqNo       <= w_reqNoNext;
        end
    end

    // A fresh edge on the acknowledged source re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irqD    <= '0;
            r_pending <= '0;
            r_clrErr  <= 1'b0;
        end else begin
            r_irqD    <= irq_in;
            r_pending <= (r_pending & ~w_ackMask) | w_edges;
            if (w_clrBad) begin
                r_clrErr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
            r_intNo <= '0;
            for (int i = 0; i < c_STACK_N; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[w_depthPop] <= r_reqNo;
            r_depth             <= w_depthPop + NO_W'(1);
            r_intNo             <= r_reqNo;
        end else begin
            r_depth <= w_depthPop;
            r_intNo <= w_topPop;
        end
    end

    // Strictly increasing stack contents cap the depth at NUM_SRC.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            assert (w_depthPop != NO_W'(NUM_SRC));
        end
    end

    assign IntrRequest = r_intrRequest;
    assign ReqNo       = r_reqNo;
    assign IntNo       = r_intNo;
    assign pending     = r_pending;
    assign depth       = r_depth;
    assign clr_err     = r_clrErr;

endmodule
`default_nettype wire

// File: tb/tb_intr_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intr_request_ctrl
//  Description : Directed and randomized bench for intr_request_ctrl against
//                a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_request_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq_in;
    logic       int_en;
    logic       intr_ack;
    logic [1:0] clrNo;
    logic       IntrRequest;
    logic [1:0] ReqNo;
    logic [1:0] IntNo;
    logic [2:0] pending;
    logic [1:0] depth;
    logic       clr_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit [2:0] mIrqD;
    bit [2:0] mPend;
    int       mStack[$];
    bit       mReq;
    int       mReqNo;
    bit       mErr;

    intr_request_ctrl #(.NUM_SRC(3), .NO_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .int_en     (int_en),
        .intr_ack   (intr_ack),
        .clrNo      (clrNo),
        .IntrRequest(IntrRequest),
        .ReqNo      (ReqNo),
        .IntNo      (IntNo),
        .pending    (pending),
        .depth      (depth),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    function automatic int mTop();
        return (mStack.size() > 0) ? mStack[$] : 0;
    endfunction

    function automatic int mBest();
        int b = 0;
        for (int i = 1; i <= 3; i++) begin
            if (mPend[i-1]) b = i;
        end
        return b;
    endfunction

    task automatic modelUpdate();
        bit [2:0] edges;
        bit [2:0] nPend;
        int       top;
        int       best;
        bit       pop;
        if (rst) begin
            mIrqD = '0;
            mPend = '0;
            mStack.delete();
            mReq   = 1'b0;
            mReqNo = 0;
            mErr   = 1'b0;
            return;
        end
        edges = irq_in & ~mIrqD;
        top   = mTop();
        best  = mBest();
        nPend = mPend;
        pop   = 1'b0;
        if (clrNo != 0) begin
            if (int'(clrNo) == top) pop = 1'b1;
            else mErr = 1'b1;
        end
        if (pop) void'(mStack.pop_back());
        if (mReq) begin
            if (intr_ack) begin
                nPend[mReqNo-1] = 1'b0;
                mStack.push_back(mReqNo);
                mReq   = 1'b0;
                mReqNo = 0;
            end else if (!int_en) begin
                mReq   = 1'b0;
                mReqNo = 0;
            end
        end else if (int_en && best > top) begin
            mReq   = 1'b1;
            mReqNo = best;
        end
        mPend = nPend | edges;
        mIrqD = irq_in;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("IntrRequest", 32'(IntrRequest), 32'(mReq));
        chk("ReqNo",       32'(ReqNo),       32'(mReqNo));
        chk("IntNo",       32'(IntNo),       32'(mTop()));
        chk("depth",       32'(depth),       32'(mStack.size()));
        chk("pending",     32'(pending),     32'(mPend));
        chk("clr_err",     32'(clr_err),     32'(mErr));
    endtask

    task automatic step();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        int r;
        rst = 1'b1; irq_in = 3'b111; int_en = 1'b0; intr_ack = 1'b0; clrNo = 2'd0;
        // Reset with all sources high
        step(); step();
        chk("rst_req",   32'(IntrRequest), 0);
        chk("rst_pend",  32'(pending), 0);
        chk("rst_depth", 32'(depth), 0);
        rst = 1'b0; irq_in = 3'b000;
        step();
        chk("rst_release_pend", 32'(pending), 0);

        // Single source
        irq_in = 3'b001; int_en = 1'b1;
        step();
        chk("single_pend", 32'(pending), 1);
        chk("single_noreq_yet", 32'(IntrRequest), 0);
        step();
        chk("single_req", 32'(IntrRequest), 1);
        chk("single_reqno", 32'(ReqNo), 1);
        intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;
        chk("single_intno", 32'(IntNo), 1);
        chk("single_depth", 32'(depth), 1);
        chk("single_pend_clr", 32'(pending), 0);
        clrNo = 2'd1;
        step();
        clrNo = 2'd0;
        chk("single_ret_intno", 32'(IntNo), 0);
        chk("single_ret_depth", 32'(depth), 0);
        step();
        chk("held_high_no_repend", 32'(pending), 0);
        irq_in = 3'b000;
        step();

        // Nesting
        irq_in = 3'b001;
        step(); step();
        intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;
        chk("nest_in1", 32'(IntNo), 1);
        irq_in = 3'b101;
        step(); step();
        chk("nest_req3", 32'(ReqNo), 3);
        intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;
        chk("nest_intno3", 32'(IntNo), 3);
        chk("nest_depth2", 32'(depth), 2);
        irq_in = 3'b111;
        step(); step();
        chk("nest_no_req2", 32'(IntrRequest), 0);
        clrNo = 2'd3;
        step();
        clrNo = 2'd0;
        chk("nest_back_to1", 32'(IntNo), 1);
        step();
        chk("nest_req2", 32'(ReqNo), 2);

        // Withdraw and reissue
        int_en = 1'b0;
        step();
        chk("wd_req", 32'(IntrRequest), 0);
        chk("wd_pend_kept", 32'(pending[1]), 1);
        int_en = 1'b1;
        step();
        chk("wd_reissue", 32'(ReqNo), 2);
        intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;

        // Bad clear
        clrNo = 2'd1;
        step();
        clrNo = 2'd0;
        chk("bad_intno", 32'(IntNo), 2);
        chk("bad_depth", 32'(depth), 2);
        chk("bad_err", 32'(clr_err), 1);
        step();
        chk("bad_err_sticky", 32'(clr_err), 1);

        // Simultaneous clear and ack
        clrNo = 2'd2;
        step();
        clrNo = 2'd0; irq_in = 3'b000;
        step();
        irq_in = 3'b100;
        step(); step();
        chk("sim_req3", 32'(ReqNo), 3);
        clrNo = 2'd1; intr_ack = 1'b1;
        step();
        clrNo = 2'd0; intr_ack = 1'b0;
        chk("sim_intno", 32'(IntNo), 3);
        chk("sim_depth", 32'(depth), 1);
        clrNo = 2'd3;
        step();
        clrNo = 2'd0;

        // Edge on the acknowledged source in the ack cycle keeps it pending
        irq_in = 3'b000; step();
        irq_in = 3'b001; step(); step();
        irq_in = 3'b000; step();
        irq_in = 3'b001; intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;
        chk("edge_wins_pend", 32'(pending), 1);
        chk("edge_wins_intno", 32'(IntNo), 1);
        clrNo = 2'd1;
        step();
        clrNo = 2'd0;
        step();
        chk("edge_wins_rereq", 32'(ReqNo), 1);

        // Reset mid-request drops everything
        rst = 1'b1; irq_in = 3'b000;
        step();
        rst = 1'b0;
        step();
        chk("midrst_req", 32'(IntrRequest), 0);
        chk("midrst_err", 32'(clr_err), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 3'($urandom);
            int_en   = ($urandom_range(0, 9) != 0);
            intr_ack = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 15)       clrNo = 2'(mTop());
            else if (r == 15) clrNo = 2'($urandom);
            else              clrNo = 2'd0;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
